bcd_convert_seq: RTL and testbench

- Sequential binary-to-packed-BCD converter using shift-and-add-3 (double dabble).
- Accepts a BIN_W-bit unsigned value, converts it over BIN_W cycles, and returns DIGITS BCD digits with a done pulse.
- Sits between counters or registers and display/UART formatting logic.
- Time-shares one set of per-digit add-3 correctors instead of a wide combinational tree.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_adjust.sv | 11 +
 rtl/bcd_convert_seq.sv | 130 +++++++++++++
 tb/tb_bcd_convert_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, state type and digit check for the BCD converter
package bcd_pkg;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  function automatic logic bcd_digit_valid(input logic [BCD_DIGIT_W-1:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - double-dabble corrector: adds 3 to a digit of 5 or more
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);

  assign q = (d >= BCD_ADJ_THRESH) ? d + BCD_ADJ_ADD : d;

endmodule

// File: rtl/bcd_convert_seq.sv
// rtl/bcd_convert_seq.sv - sequential binary to packed BCD converter; BCD_CONVERT_BLANK_EN adds blank output
module bcd_convert_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          ready,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
`ifdef BCD_CONVERT_BLANK_EN
  output logic [DIGITS-1:0]             blank,
`endif
  output logic                          digit_err
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  function automatic longint pow10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  if (pow10(DIGITS) < (longint'(1) << BIN_W)) begin : g_param_check
    $error("bcd_convert_seq: DIGITS cannot represent every BIN_W-bit value");
  end

  bcd_state_t          state;
  logic [BIN_W-1:0]    bin_sr;
  logic [SCR_W-1:0]    scratch;
  logic [CNT_W-1:0]    cnt;
  logic [SCR_W-1:0]    adj;
  logic [SCR_W+BIN_W-1:0] shifted;
  logic [SCR_W-1:0]    scratch_sh;
  logic [BIN_W-1:0]    bin_sh;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d (scratch[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .q (adj[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  // Corrected digits shift as one word with the binary remainder; the MSB of
  // the scratch falls off, which the parameter check guarantees is always 0.
  assign shifted    = {adj, bin_sr} << 1;
  assign scratch_sh = shifted[SCR_W+BIN_W-1:BIN_W];
  assign bin_sh     = shifted[BIN_W-1:0];

`ifdef BCD_CONVERT_BLANK_EN
  logic [DIGITS-1:0] blank_nx;

  always_comb begin
    blank_nx = '0;
    blank_nx[DIGITS-1] = (DIGITS > 1) && (scratch_sh[SCR_W-1 -: BCD_DIGIT_W] == '0);
    for (int i = DIGITS - 2; i >= 1; i--)
      blank_nx[i] = blank_nx[i+1] && (scratch_sh[BCD_DIGIT_W*i +: BCD_DIGIT_W] == '0);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bin_sr  <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd_out <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b1;
`ifdef BCD_CONVERT_BLANK_EN
      blank   <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            bin_sr  <= bin_in;
            scratch <= '0;
            cnt     <= '0;
            state   <= SHIFT;
            busy    <= 1'b1;
            ready   <= 1'b0;
          end else begin
            state   <= IDLE;
            busy    <= 1'b0;
            ready   <= 1'b1;
          end
        end
        SHIFT: begin
          bin_sr  <= bin_sh;
          scratch <= scratch_sh;
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            bcd_out <= scratch_sh;
`ifdef BCD_CONVERT_BLANK_EN
            blank   <= blank_nx;
`endif
            state   <= DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            ready   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    digit_err = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (!bcd_digit_valid(bcd_out[BCD_DIGIT_W*i +: BCD_DIGIT_W])) digit_err = 1'b1;
  end

endmodule

// File: tb/tb_bcd_convert_seq.sv
// tb/tb_bcd_convert_seq.sv - self-checking bench for bcd_convert_seq
module tb_bcd_convert_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bin_in = '0;
  logic        ready, busy, done, digit_err;
  logic [19:0] bcd_out;
`ifdef BCD_CONVERT_BLANK_EN
  logic [4:0]  blank;
`endif

  int total = 0;
  int bad = 0;
  int err_seen = 0;

  bcd_convert_seq #(.BIN_W(16), .DIGITS(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bin_in    (bin_in),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
`ifdef BCD_CONVERT_BLANK_EN
    .blank     (blank),
`endif
    .digit_err (digit_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && digit_err !== 1'b0) err_seen++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
    logic [4:0]  blank;
  } vec_t;

  vec_t vecs[8];

  // Reference: decimal digits by repeated division.
  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r = '0;
    int x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] blank_of(input logic [19:0] b);
    logic [4:0] r = '0;
    for (int i = 1; i < 5; i++) r[i] = ((b >> (4*i)) == 20'd0);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT ready; returns at the negedge where done is seen.
  task automatic convert(input logic [15:0] v, output logic [19:0] res, output int lat);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = 16'($urandom);
    lat = 0;
    res = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        res = bcd_out;
        break;
      end
    end
    if (lat == 0) check("convert_timeout", 32'(lat), 32'd17);
  endtask

  logic [19:0] res;
  int lat;

  initial begin
    vecs[0] = '{16'd0,     20'h00000, 5'b11110};
    vecs[1] = '{16'd65535, 20'h65535, 5'b00000};
    vecs[2] = '{16'd1234,  20'h01234, 5'b10000};
    vecs[3] = '{16'd9999,  20'h09999, 5'b10000};
    vecs[4] = '{16'd10000, 20'h10000, 5'b00000};
    vecs[5] = '{16'd7,     20'h00007, 5'b11110};
    vecs[6] = '{16'd59,    20'h00059, 5'b11100};
    vecs[7] = '{16'd39999, 20'h39999, 5'b00000};

    repeat (3) @(negedge clk);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_bcd", 32'(bcd_out), 32'd0);
`ifdef BCD_CONVERT_BLANK_EN
    check("reset_blank", 32'(blank), 32'b11110);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      convert(vecs[i].bin, res, lat);
      check($sformatf("vec%0d_bcd", i), 32'(res), 32'(vecs[i].bcd));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd17);
`ifdef BCD_CONVERT_BLANK_EN
      check($sformatf("vec%0d_blank", i), 32'(blank), 32'(vecs[i].blank));
`endif
      @(negedge clk);
    end

    // start held through SHIFT with a different bin_in must not queue a second job
    begin
      int busy_n = 0, dones = 0;
      start = 1'b1;
      bin_in = 16'd9999;
      @(posedge clk);
      #1 bin_in = 16'd1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (busy) busy_n++;
        if (done) begin
          dones++;
          res = bcd_out;
          start = 1'b0;
          break;
        end
      end
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done) dones++;
        if (busy) busy_n++;
      end
      check("ignore_bcd", 32'(res), 32'h09999);
      check("ignore_dones", 32'(dones), 32'd1);
      check("ignore_busy_cycles", 32'(busy_n), 32'd16);
    end

    // back-to-back with start held, alternating operands
    begin
      int got = 0, since = 0, ready_bad = 0;
      int vals[2] = '{42, 777};
      start = 1'b1;
      bin_in = 16'd42;
      for (int c = 0; c < 200 && got < 4; c++) begin
        @(negedge clk);
        since++;
        if (ready !== done) ready_bad++;
        if (done) begin
          check($sformatf("b2b_bcd%0d", got), 32'(bcd_out), 32'(to_bcd(vals[got % 2])));
          if (got > 0) check($sformatf("b2b_period%0d", got), 32'(since), 32'd17);
          since = 0;
          got++;
          bin_in = 16'(vals[got % 2]);
          if (got == 4) start = 1'b0;
        end
      end
      start = 1'b0;
      check("b2b_count", 32'(got), 32'd4);
      check("b2b_ready_only_in_done", 32'(ready_bad), 32'd0);
      @(negedge clk);
    end

    // reset in the middle of a conversion
    begin
      int dones = 0;
      start = 1'b1;
      bin_in = 16'd500;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (8) begin
        @(negedge clk);
        if (done) dones++;
      end
      rst = 1'b1;
      @(negedge clk);
      check("midrst_ready", 32'(ready), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_bcd", 32'(bcd_out), 32'd0);
      rst = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (done) dones++;
      end
      check("midrst_no_done", 32'(dones), 32'd0);
      convert(16'd500, res, lat);
      check("midrst_fresh_bcd", 32'(res), 32'h00500);
      @(negedge clk);
    end

    for (int i = 0; i < 300; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      convert(v, res, lat);
      check($sformatf("rand_bcd_%0d", v), 32'(res), 32'(to_bcd(int'(v))));
`ifdef BCD_CONVERT_BLANK_EN
      check($sformatf("rand_blank_%0d", v), 32'(blank), 32'(blank_of(to_bcd(int'(v)))));
`endif
      if ((i % 7) == 0) @(negedge clk);
    end

    check("digit_err_never", 32'(err_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
